// File: rtl/div_if.sv
// Handshake and operand/result bundle between the CPU controller and the
// iterative divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             divu_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;

    modport master (
        output div_start,
        output divu_start,
        output dividend,
        output divisor,
        input  q,
        input  r,
        input  busy,
        input  done
    );

    modport slave (
        input  div_start,
        input  divu_start,
        input  dividend,
        input  divisor,
        output q,
        output r,
        output busy,
        output done
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU.
// Quotient goes to LO and remainder goes to HI, with MIPS rounding:
// truncation toward zero, and the remainder takes the sign of the dividend.
// The controller stalls on busy and picks up the result on the one-cycle
// done pulse.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave div_bus
);
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

    logic             start;
    logic             sgn;
    logic             dvdNeg;
    logic             dvsNeg;
    logic [WIDTH-1:0] dvdMag;
    logic [WIDTH-1:0] dvsMag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand magnitudes and one restoring step, computed from the current
    // registers. Negating 0x80000000 wraps to itself, which is the correct
    // unsigned magnitude.
    always_comb begin
        start   = div_bus.div_start | div_bus.divu_start;
        sgn     = div_bus.div_start;
        dvdNeg  = sgn & div_bus.dividend[WIDTH-1];
        dvsNeg  = sgn & div_bus.divisor[WIDTH-1];
        dvdMag  = dvdNeg ? -div_bus.dividend : div_bus.dividend;
        dvsMag  = dvsNeg ? -div_bus.divisor : div_bus.divisor;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers. A reset clears everything so an aborted
    // operation leaves no partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            zero_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            zero_q <= zero_d;
            q_q    <= q_d;
            r_q    <= r_d;
            done_q <= done_d;
        end
    end

    // Next-state and datapath updates. Start requests are only looked at in
    // IDLE, and done is high only in the cycle after FIX.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = dvdMag;
                    dvsr_d  = dvsMag;
                    cnt_d   = '0;
                    negq_d  = dvdNeg ^ dvsNeg;
                    negr_d  = dvdNeg;
                    zero_d  = (div_bus.divisor == '0);
                    state_d = CALC;
                end
            end
            CALC: begin
                // A negative trial result means the divisor did not fit, so
                // the shifted remainder is kept (restored) and a 0 enters the
                // quotient.
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the remainder is the dividend
                // magnitude, and re-applying the dividend sign gives back the
                // original dividend. Only the quotient needs to be forced.
                q_d     = zero_q ? '1 : (negq_q ? -quo_q : quo_q);
                r_d     = negr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_bus.q    = q_q;
    assign div_bus.r    = r_q;
    assign div_bus.busy = (state_q != IDLE);
    assign div_bus.done = done_q;
endmodule
